// File: rtl/tube_pkg.sv
// Shared definitions for the 7-segment tube display arbiter: word layout,
// sign codes, the arbiter state type and a BCD digit check.
package tube_pkg;

  localparam int          TUBE_W         = 16;
  localparam logic [3:0]  SIGN_POS       = 4'h0;
  localparam logic [3:0]  SIGN_NEG       = 4'h1;
  localparam logic [15:0] TUBE_IDLE_WORD = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } tube_state_e;

  function automatic logic digit_ok(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/tube_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... (wrapping at
// NREQ) for the first requester that is high and not excluded.
module tube_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] excl,
  output logic [IW-1:0]   win,
  output logic            found
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest eligible candidate wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (req[idx] && !excl[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tube_arbiter.sv
// Round-robin time-sharing of one 4-digit tube driver among NREQ requesters,
// with a minimum dwell per tenure. Optional urgent requester 0: TUBE_ARB_PREEMPT_EN.
module tube_arbiter
  import tube_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26,
  localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [TUBE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic [IW-1:0]          active_id,
  output logic [TUBE_W-1:0]      disp_data,
  output logic                   disp_valid,
  output logic                   fmt_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  tube_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    ptr;
  logic [NREQ-1:0]  excl;
  logic [IW-1:0]    win;
  logic             found;
  logic             preempt;
  logic             start;
  logic             stop;
  logic [IW-1:0]    new_id;

  // While showing, the current owner is never its own RR successor.
  assign excl = (state == SHOW) ? (NREQ'(1) << active_id) : '0;

  tube_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .excl  (excl),
    .win   (win),
    .found (found)
  );

`ifdef TUBE_ARB_PREEMPT_EN
  logic req0_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) req0_q <= 1'b0;
    else       req0_q <= req[0];
  end

  assign preempt = (state == SHOW) && (active_id != '0) && req[0] && !req0_q;
`else
  assign preempt = 1'b0;
`endif

  // start: load a new owner with a fresh dwell; stop: release the display.
  always_comb begin
    start  = 1'b0;
    stop   = 1'b0;
    new_id = win;
    case (state)
      IDLE: start = found;
      SHOW: begin
        if (preempt) begin
          start  = 1'b1;
          new_id = '0;
        end else if (!req[active_id] || cnt == LAST) begin
          if (found)               start = 1'b1;
          else if (!req[active_id]) stop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= IW'(NREQ - 1);
      grant      <= '0;
      active_id  <= '0;
      disp_data  <= TUBE_IDLE_WORD;
      disp_valid <= 1'b0;
    end else if (start) begin
      state      <= SHOW;
      cnt        <= '0;
      grant      <= NREQ'(1) << new_id;
      active_id  <= new_id;
      disp_data  <= req_data[TUBE_W*int'(new_id) +: TUBE_W];
      disp_valid <= 1'b1;
      if (!preempt) ptr <= new_id;
    end else if (stop) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= '0;
      active_id  <= '0;
      disp_data  <= TUBE_IDLE_WORD;
      disp_valid <= 1'b0;
    end else if (state == SHOW) begin
      cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
      disp_data <= req_data[TUBE_W*int'(active_id) +: TUBE_W];
    end
  end

  assign fmt_err = disp_valid &&
                   !(((disp_data[15:12] == SIGN_POS) || (disp_data[15:12] == SIGN_NEG)) &&
                     digit_ok(disp_data[11:8]) && digit_ok(disp_data[7:4]) &&
                     digit_ok(disp_data[3:0]));

endmodule

// File: tb/tb_tube_arbiter.sv
// Directed bench for tube_arbiter (NREQ=4, DWELL_CYCLES=8); the urgent
// requester case follows TUBE_ARB_PREEMPT_EN when it is defined.
module tb_tube_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 8;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  active_id;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        fmt_err;

  int checks   = 0;
  int failures = 0;

  tube_arbiter #(.NREQ(NREQ), .DWELL_CYCLES(DWELL), .CNT_W(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .active_id  (active_id),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .fmt_err    (fmt_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    req_data[16*i +: 16] = w;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    req      = 4'b0000;
    req_data = '0;
    set_word(0, 16'h0123);
    set_word(1, 16'h1111);
    set_word(2, 16'h2222);
    set_word(3, 16'h3333);
    tick();
    tick();
    check_eq("rst_grant", grant, 4'b0000);
    check_eq("rst_id", active_id, 2'd0);
    check_eq("rst_data", disp_data, 16'h0000);
    check_eq("rst_valid", disp_valid, 1'b0);
    check_eq("rst_fmt", fmt_err, 1'b0);
    rstn = 1'b1;
    tick();
    check_eq("no_req_grant", grant, 4'b0000);

    // single requester holds indefinitely through dwell restarts
    req = 4'b0001;
    tick();
    check_eq("r0_grant", grant, 4'b0001);
    check_eq("r0_data", disp_data, 16'h0123);
    check_eq("r0_valid", disp_valid, 1'b1);
    check_eq("r0_id", active_id, 2'd0);
    for (int i = 0; i < 20; i++) begin
      check_eq("r0_hold", {grant, 3'b0, disp_valid}, {4'b0001, 4'b0001});
      tick();
    end
    req = 4'b0000;
    tick();
    check_eq("idle_grant", grant, 4'b0000);
    check_eq("idle_valid", disp_valid, 1'b0);
    check_eq("idle_data", disp_data, 16'h0000);

    // two competitors alternate with exact 8-cycle tenures
    req = 4'b0110;
    tick();
    for (int i = 0; i < DWELL; i++) begin
      check_eq("rr_g1", {grant, 3'b0, disp_valid}, {4'b0010, 4'b0001});
      tick();
    end
    check_eq("rr_d2", disp_data, 16'h2222);
    for (int i = 0; i < DWELL; i++) begin
      check_eq("rr_g2", {grant, 3'b0, disp_valid}, {4'b0100, 4'b0001});
      tick();
    end
    check_eq("rr_back1", grant, 4'b0010);
    check_eq("rr_back1_data", disp_data, 16'h1111);

    // owner drops at dwell cycle 3 with requester 3 pending
    tick();
    tick();
    tick();
    req = 4'b1000;
    tick();
    check_eq("drop_grant", grant, 4'b1000);
    check_eq("drop_id", active_id, 2'd3);
    check_eq("drop_data", disp_data, 16'h3333);
    req = 4'b1010;
    for (int i = 0; i < DWELL; i++) begin
      check_eq("fresh_dwell", grant, 4'b1000);
      tick();
    end
    check_eq("after_fresh", grant, 4'b0010);
    req = 4'b1000;
    tick();
    check_eq("back_to3", grant, 4'b1000);

    // format flag follows live data
    set_word(3, 16'h0A15);
    tick();
    check_eq("fmt_data_bad", disp_data, 16'h0A15);
    check_eq("fmt_bad", fmt_err, 1'b1);
    set_word(3, 16'h1095);
    tick();
    check_eq("fmt_data_neg", disp_data, 16'h1095);
    check_eq("fmt_neg", fmt_err, 1'b0);
    set_word(3, 16'h2095);
    tick();
    check_eq("fmt_sign", fmt_err, 1'b1);
    set_word(3, 16'h3333);

    // asynchronous reset mid-tenure
    rstn = 1'b0;
    #1;
    check_eq("arst_grant", grant, 4'b0000);
    check_eq("arst_data", disp_data, 16'h0000);
    check_eq("arst_valid", disp_valid, 1'b0);
    check_eq("arst_fmt", fmt_err, 1'b0);
    check_eq("arst_id", active_id, 2'd0);
    req = 4'b1001;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < DWELL; i++) begin
      check_eq("post_rst_r0", grant, 4'b0001);
      tick();
    end
    check_eq("post_rst_r3", grant, 4'b1000);

    // requester 2 owns; requester 0 rises at dwell cycle 2
    req = 4'b0000;
    tick();
    check_eq("pre_idle", grant, 4'b0000);
    req = 4'b1100;
    tick();
    check_eq("pre_r2", grant, 4'b0100);
    tick();
    tick();
    req = 4'b1101;
    tick();
`ifdef TUBE_ARB_PREEMPT_EN
    check_eq("preempt_id", active_id, 2'd0);
    for (int i = 0; i < DWELL; i++) begin
      check_eq("preempt_r0", grant, 4'b0001);
      tick();
    end
`else
    for (int i = 0; i < DWELL - 3; i++) begin
      check_eq("nopre_r2", grant, 4'b0100);
      tick();
    end
`endif
    check_eq("pre_next_r3", grant, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
